// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: valid/ready circular buffer between two pipeline stages.
// A synchronous flush discards every in-flight entry.
// Optional build macro: PIPE_BUF_STATS_EN adds stall_cycles and flushed_entries counters.
module pipe_stage_buf #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 2,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
`ifdef PIPE_BUF_STATS_EN
    output logic [31:0]      stall_cycles,
    output logic [31:0]      flushed_entries,
`endif
    output logic [CNT_W-1:0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wp;
    logic [PTR_W-1:0] rp;
    logic [CNT_W-1:0] cnt;
    logic             push;
    logic             pop;

    // Handshake qualifiers: only flush reaches these combinationally.
    always_comb begin
        in_ready  = (cnt != CNT_W'(DEPTH)) && !flush;
        out_valid = (cnt != CNT_W'(0)) && !flush;
        push      = in_valid && in_ready;
        pop       = out_valid && out_ready;
        out_data  = mem[rp];
        count     = cnt;
    end

    // Entry storage; flush leaves contents in place, only reset clears them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[wp] <= in_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else if (flush) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (push) begin
                wp <= wp + PTR_W'(1);
            end
            if (pop) begin
                rp <= rp + PTR_W'(1);
            end
            if (push && !pop) begin
                cnt <= cnt + CNT_W'(1);
            end else if (pop && !push) begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

`ifdef PIPE_BUF_STATS_EN
    logic [32:0] flushed_sum_c;

    // Widened sum so saturation can be detected from the carry.
    always_comb begin
        flushed_sum_c = {1'b0, flushed_entries} + 33'(cnt);
    end

    // Saturating stall and flush-loss counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles    <= '0;
            flushed_entries <= '0;
        end else begin
            if (out_valid && !out_ready && (stall_cycles != 32'hFFFF_FFFF)) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            if (flush) begin
                flushed_entries <= flushed_sum_c[32] ? 32'hFFFF_FFFF : flushed_sum_c[31:0];
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed bench for pipe_stage_buf: a DEPTH=2 instance for streaming and a
// DEPTH=4 instance for backpressure, wrap, flush, async reset and stats.
module tb_pipe_stage_buf;

    logic clk = 1'b0;
    logic clk_run = 1'b0;
    logic rst_n = 1'b1;

    // DEPTH=2 instance signals
    logic        a_flush = 1'b0, a_in_valid = 1'b0, a_out_ready = 1'b0;
    logic [31:0] a_in_data = '0;
    logic        a_in_ready, a_out_valid;
    logic [31:0] a_out_data;
    logic [1:0]  a_count;

    // DEPTH=4 instance signals
    logic        b_flush = 1'b0, b_in_valid = 1'b0, b_out_ready = 1'b0;
    logic [31:0] b_in_data = '0;
    logic        b_in_ready, b_out_valid;
    logic [31:0] b_out_data;
    logic [2:0]  b_count;

`ifdef PIPE_BUF_STATS_EN
    logic [31:0] a_stall, a_fe, b_stall, b_fe;
    logic [31:0] fe_before;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    pipe_stage_buf #(.WIDTH(32), .DEPTH(2)) u_d2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (a_flush),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .in_data   (a_in_data),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .out_data  (a_out_data),
`ifdef PIPE_BUF_STATS_EN
        .stall_cycles    (a_stall),
        .flushed_entries (a_fe),
`endif
        .count     (a_count)
    );

    pipe_stage_buf #(.WIDTH(32), .DEPTH(4)) u_d4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (b_flush),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_data   (b_in_data),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_data  (b_out_data),
`ifdef PIPE_BUF_STATS_EN
        .stall_cycles    (b_stall),
        .flushed_entries (b_fe),
`endif
        .count     (b_count)
    );

    always begin
        #5;
        if (clk_run) clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Shorthand for the DEPTH=4 instance state after an edge
    task automatic chk_b(input string tag, input logic [2:0] cnt, input logic vld, input logic [31:0] data);
        check({tag, "_count"}, 64'(b_count), 64'(cnt));
        check({tag, "_valid"}, 64'(b_out_valid), 64'(vld));
        if (vld) check({tag, "_data"}, 64'(b_out_data), 64'(data));
    endtask

    initial begin
        // Reset with no clock running
        #2 rst_n = 1'b0;
        #3;
        check("rst_a_count", 64'(a_count), 64'd0);
        check("rst_a_valid", 64'(a_out_valid), 64'd0);
        check("rst_a_data",  64'(a_out_data), 64'd0);
        check("rst_b_count", 64'(b_count), 64'd0);
        check("rst_b_valid", 64'(b_out_valid), 64'd0);
        check("rst_b_data",  64'(b_out_data), 64'd0);
        #10 rst_n = 1'b1;
        #1;
        check("rel_a_in_ready", 64'(a_in_ready), 64'd1);
        check("rel_b_in_ready", 64'(b_in_ready), 64'd1);
`ifdef PIPE_BUF_STATS_EN
        check("rst_b_stall", 64'(b_stall), 64'd0);
        check("rst_b_fe",    64'(b_fe), 64'd0);
`endif
        clk_run = 1'b1;
        tick();

        // Streaming through DEPTH=2: each word visible right after its push edge
        a_out_ready = 1'b1;
        a_in_valid  = 1'b1;
        a_in_data   = 32'h1;
        for (int i = 1; i <= 16; i++) begin
            tick();
            check($sformatf("stream_data_%0d", i), 64'(a_out_data), 64'(i));
            check($sformatf("stream_valid_%0d", i), 64'(a_out_valid), 64'd1);
            check($sformatf("stream_ready_%0d", i), 64'(a_in_ready), 64'd1);
            a_in_data = 32'(i + 1);
        end
        a_in_valid = 1'b0;
        tick();
        check("stream_drain_count", 64'(a_count), 64'd0);
        check("stream_drain_valid", 64'(a_out_valid), 64'd0);

        // Fill DEPTH=4 with A0..A3 while downstream is held
        b_out_ready = 1'b0;
        b_in_valid  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            b_in_data = 32'hA0 + 32'(i);
            tick();
        end
        check("full_count", 64'(b_count), 64'd4);
        check("full_in_ready", 64'(b_in_ready), 64'd0);
        check("full_head", 64'(b_out_data), 64'hA0);
        // Fifth word offered, must be held
        b_in_data = 32'hA4;
        tick();
        chk_b("hold", 3'd4, 1'b1, 32'hA0);
        // Release downstream: full buffer pops but cannot push in the same cycle
        b_out_ready = 1'b1;
        tick();
        chk_b("pop_a0", 3'd3, 1'b1, 32'hA1);
        check("pop_a0_ready", 64'(b_in_ready), 64'd1);
        tick();
        chk_b("push_a4", 3'd3, 1'b1, 32'hA2);
        b_in_valid = 1'b0;
        tick();
        chk_b("pop_a2", 3'd2, 1'b1, 32'hA3);
        tick();
        chk_b("pop_a3_wrap", 3'd1, 1'b1, 32'hA4);
        tick();
        chk_b("empty_after_a4", 3'd0, 1'b0, 32'h0);

        // Simultaneous push/pop at count=2
        b_out_ready = 1'b0;
        b_in_valid  = 1'b1;
        b_in_data   = 32'hB0;
        tick();
        b_in_data   = 32'hB1;
        tick();
        chk_b("two_held", 3'd2, 1'b1, 32'hB0);
        b_out_ready = 1'b1;
        b_in_data   = 32'hB2;
        tick();
        chk_b("pp_b2", 3'd2, 1'b1, 32'hB1);
        b_in_data = 32'hB3;
        tick();
        chk_b("pp_b3", 3'd2, 1'b1, 32'hB2);
        b_in_valid = 1'b0;
        tick();
        chk_b("pp_drain1", 3'd1, 1'b1, 32'hB3);
        tick();
        chk_b("pp_drain2", 3'd0, 1'b0, 32'h0);

        // Flush with three entries while both handshakes are offered
        b_out_ready = 1'b0;
        b_in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            b_in_data = 32'hC0 + 32'(i);
            tick();
        end
        check("pre_flush_count", 64'(b_count), 64'd3);
`ifdef PIPE_BUF_STATS_EN
        fe_before = b_fe;
`endif
        b_flush     = 1'b1;
        b_out_ready = 1'b1;
        b_in_data   = 32'hC3;
        #1;
        check("flush_in_ready", 64'(b_in_ready), 64'd0);
        check("flush_out_valid", 64'(b_out_valid), 64'd0);
        tick();
        b_flush = 1'b0;
        #1;
        chk_b("post_flush", 3'd0, 1'b0, 32'h0);
        check("post_flush_ready", 64'(b_in_ready), 64'd1);
`ifdef PIPE_BUF_STATS_EN
        check("flushed_entries", 64'(b_fe), 64'(fe_before + 32'd3));
`endif
        tick();
        chk_b("accept_c3", 3'd1, 1'b1, 32'hC3);
        b_in_valid = 1'b0;
        tick();
        chk_b("drain_c3", 3'd0, 1'b0, 32'h0);

        // Stall on a single entry; saturate the stall counter when present
        b_out_ready = 1'b0;
        b_in_valid  = 1'b1;
        b_in_data   = 32'hD0;
        tick();
        b_in_valid  = 1'b0;
        chk_b("stall_entry", 3'd1, 1'b1, 32'hD0);
`ifdef PIPE_BUF_STATS_EN
        force u_d4.stall_cycles = 32'hFFFF_FFFE;
        #1;
        release u_d4.stall_cycles;
`endif
        tick();
        tick();
        tick();
        chk_b("stall_hold", 3'd1, 1'b1, 32'hD0);
`ifdef PIPE_BUF_STATS_EN
        check("stall_saturate", 64'(b_stall), 64'hFFFF_FFFF);
`endif

        // Async reset mid-operation clears state without a clock edge
        #2 rst_n = 1'b0;
        #1;
        check("midrst_count", 64'(b_count), 64'd0);
        check("midrst_valid", 64'(b_out_valid), 64'd0);
        check("midrst_data",  64'(b_out_data), 64'd0);
`ifdef PIPE_BUF_STATS_EN
        check("midrst_stall", 64'(b_stall), 64'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("midrst_ready", 64'(b_in_ready), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
